// File: rtl/aes_host_pkg.sv
// aes_host_pkg: shared types and constants for the AES host controller
package aes_host_pkg;
    typedef enum logic [2:0] {
        IDLE, ENC_LD, ENC_WAIT, KEY_LD, KEY_WAIT, DEC_LD, DEC_WAIT, RSP
    } state_t;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;
    typedef logic [127:0] block_t;
endpackage

// File: rtl/aes_host_tmo.sv
// aes_host_tmo: wait-state timeout counter; expired_o fires on the cycle the count would reach TIMEOUT_CYCLES
module aes_host_tmo #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    // clear has priority over counting
    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + TW'(1) : cnt_q;
    // count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
    assign expired_o = en_i && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/aes_host_ctrl.sv
// aes_host_ctrl: request/response front end that sequences the cipher and inverse-cipher core strobes
module aes_host_ctrl import aes_host_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic [127:0] req_key,
    input  logic [127:0] req_text,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_mode,
    output logic         rsp_err,
    output logic         enc_ld,
    output logic         dec_kld,
    output logic         dec_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text,
    input  logic         enc_done,
    input  logic [127:0] enc_text_out,
    input  logic         dec_kdone,
    input  logic         dec_done,
    input  logic [127:0] dec_text_out
);
    state_t state_q, state_d;
    block_t key_q, key_d, text_q, text_d, data_q, data_d, cached_q, cached_d;
    logic   mode_q, mode_d, err_q, err_d, kvalid_q, kvalid_d;
    logic   tmo_clr, tmo_en, tmo_exp;

    aes_host_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_exp)
    );

    // next state, datapath updates and strobes decoded from the current state
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        text_d    = text_q;
        mode_d    = mode_q;
        data_d    = data_q;
        err_d     = err_q;
        cached_d  = cached_q;
        kvalid_d  = kvalid_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        enc_ld    = 1'b0;
        dec_kld   = 1'b0;
        dec_ld    = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    key_d   = req_key;
                    text_d  = req_text;
                    mode_d  = req_mode;
                    state_d = req_mode == MODE_ENC ? ENC_LD :
                              (kvalid_q && req_key == cached_q) ? DEC_LD : KEY_LD;
                end
            end
            ENC_LD: begin
                enc_ld  = 1'b1;
                tmo_clr = 1'b1;
                state_d = ENC_WAIT;
            end
            KEY_LD: begin
                dec_kld = 1'b1;
                tmo_clr = 1'b1;
                state_d = KEY_WAIT;
            end
            DEC_LD: begin
                dec_ld  = 1'b1;
                tmo_clr = 1'b1;
                state_d = DEC_WAIT;
            end
            ENC_WAIT: begin
                tmo_en = 1'b1;
                if (enc_done) begin
                    data_d  = enc_text_out;
                    err_d   = 1'b0;
                    state_d = RSP;
                end else if (tmo_exp) begin
                    data_d   = '0;
                    err_d    = 1'b1;
                    kvalid_d = 1'b0;
                    state_d  = RSP;
                end
            end
            KEY_WAIT: begin
                tmo_en = 1'b1;
                if (dec_kdone) begin
                    cached_d = key_q;
                    kvalid_d = 1'b1;
                    state_d  = DEC_LD;
                end else if (tmo_exp) begin
                    data_d   = '0;
                    err_d    = 1'b1;
                    kvalid_d = 1'b0;
                    state_d  = RSP;
                end
            end
            DEC_WAIT: begin
                tmo_en = 1'b1;
                if (dec_done) begin
                    data_d  = dec_text_out;
                    err_d   = 1'b0;
                    state_d = RSP;
                end else if (tmo_exp) begin
                    data_d   = '0;
                    err_d    = 1'b1;
                    kvalid_d = 1'b0;
                    state_d  = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers; reset abandons any request in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            key_q    <= '0;
            text_q   <= '0;
            mode_q   <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            cached_q <= '0;
            kvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            text_q   <= text_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            err_q    <= err_d;
            cached_q <= cached_d;
            kvalid_q <= kvalid_d;
        end
    end

    assign core_key  = key_q;
    assign core_text = text_q;
    assign rsp_data  = data_q;
    assign rsp_mode  = mode_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_aes_host_ctrl.sv
// tb_aes_host_ctrl: vector table, reset corner cases and random traffic against a key-cache/timing reference model
module tb_aes_host_ctrl;
    import aes_host_pkg::*;

    localparam int TMO = 64;
    localparam block_t K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t K3 = 128'hffeeddccbbaa99887766554433221100;
    localparam block_t P  = 128'h00112233445566778899aabbccddeeff;
    localparam block_t C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam block_t T2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam block_t R2 = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct {
        logic   mode;
        block_t key;
        block_t text;
        block_t result;
        int     lat;
        int     klat;
        int     bp;
        logic   x_kld;
        logic   x_err;
    } vec_t;

    logic   clk = 1'b0, rst = 1'b0;
    logic   req_valid = 1'b0, req_mode = 1'b0, rsp_ready = 1'b0;
    block_t req_key = '0, req_text = '0;
    logic   enc_done = 1'b0, dec_kdone = 1'b0, dec_done = 1'b0;
    block_t enc_text_out = '0, dec_text_out = '0;
    logic   req_ready, rsp_valid, rsp_mode, rsp_err, enc_ld, dec_kld, dec_ld;
    block_t rsp_data, core_key, core_text;

    int     n_chk = 0, n_fail = 0;
    logic   m_valid = 1'b0;
    block_t m_key = '0;

    always #5 clk = ~clk;

    aes_host_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_text(req_text),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_mode(rsp_mode), .rsp_err(rsp_err),
        .enc_ld(enc_ld), .dec_kld(dec_kld), .dec_ld(dec_ld),
        .core_key(core_key), .core_text(core_text),
        .enc_done(enc_done), .enc_text_out(enc_text_out),
        .dec_kdone(dec_kdone), .dec_done(dec_done), .dec_text_out(dec_text_out)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_quiet_outputs(input string name);
        chk({name, "_flags"}, 128'({enc_ld, dec_kld, dec_ld, rsp_valid, rsp_err, rsp_mode, req_ready}), 128'(7'b0000001));
        chk({name, "_rsp_data"}, rsp_data, '0);
        chk({name, "_core_key"}, core_key, '0);
        chk({name, "_core_text"}, core_text, '0);
    endtask

    // one request end to end; the bench plays both AES cores and keeps a pending request up while the response waits
    task automatic txn(input vec_t v);
        int cyc, kld_c, ld_c, done_at, kdone_at, n_enc, n_kld, n_ld, ld_x, rsp_x;
        logic bad, kok, dok;
        block_t hold;
        kld_c = -1; ld_c = -1; done_at = -1; kdone_at = -1;
        n_enc = 0; n_kld = 0; n_ld = 0; bad = 1'b0;
        chk("req_ready_idle", 128'(req_ready), 128'(1'b1));
        req_valid = 1'b1; req_mode = v.mode; req_key = v.key; req_text = v.text;
        @(posedge clk); #1;
        req_valid = 1'b0; req_key = {4{$urandom()}}; req_text = {4{$urandom()}};
        cyc = 1;
        while (!rsp_valid && cyc < 250) begin
            {enc_done, dec_done, dec_kdone} = 3'b000;
            enc_text_out = {4{$urandom()}};
            dec_text_out = {4{$urandom()}};
            if ($countones({enc_ld, dec_kld, dec_ld}) > 1 || core_key !== v.key ||
                core_text !== v.text || req_ready !== 1'b0) bad = 1'b1;
            if (enc_ld || dec_ld) begin
                ld_c = cyc;
                n_enc += int'(enc_ld);
                n_ld += int'(dec_ld);
                if (v.lat >= 1) done_at = cyc + v.lat;
            end
            if (dec_kld) begin
                kld_c = cyc;
                n_kld++;
                if (v.klat >= 1) kdone_at = cyc + v.klat;
            end
            if (cyc == kld_c + 1) begin enc_done = 1'b1; dec_done = 1'b1; end
            if (cyc == ld_c + 1) begin
                if (v.mode) enc_done = 1'b1;
                else begin dec_done = 1'b1; dec_kdone = 1'b1; end
            end
            if (cyc == kdone_at) dec_kdone = 1'b1;
            if (cyc == done_at) begin
                if (v.mode) begin dec_done = 1'b1; dec_text_out = v.result; end
                else begin enc_done = 1'b1; enc_text_out = v.result; end
            end
            @(posedge clk); #1;
            cyc++;
        end
        {enc_done, dec_done, dec_kdone} = 3'b000;
        kok = v.klat >= 1 && v.klat <= TMO;
        dok = v.lat >= 1 && v.lat <= TMO;
        ld_x = !v.x_kld ? 1 : kok ? 2 + v.klat : -1;
        rsp_x = (v.x_kld && !kok) ? 2 + TMO : dok ? ld_x + v.lat + 1 : ld_x + TMO + 1;
        chk("monitor", 128'(bad), '0);
        chk("n_enc_ld", 128'(n_enc), 128'(!v.mode));
        chk("n_dec_kld", 128'(n_kld), 128'(v.x_kld));
        chk("n_dec_ld", 128'(n_ld), 128'(v.mode && ld_x > 0));
        chk("ld_cycle", 128'(ld_c), 128'(ld_x));
        chk("rsp_cycle", 128'(cyc), 128'(rsp_x));
        chk("rsp_err", 128'(rsp_err), 128'(v.x_err));
        chk("rsp_mode", 128'(rsp_mode), 128'(v.mode));
        chk("rsp_data", rsp_data, v.x_err ? '0 : v.result);
        hold = rsp_data; bad = 1'b0;
        req_valid = 1'b1; req_mode = ~v.mode;
        repeat (v.bp) begin
            @(posedge clk); #1;
            if (!rsp_valid || req_ready || rsp_data !== hold || rsp_err !== v.x_err ||
                rsp_mode !== v.mode) bad = 1'b1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_stable", 128'(bad), '0);
        chk("handshake_no_accept", 128'({rsp_valid, req_ready, enc_ld, dec_kld, dec_ld}), 128'(5'b01000));
        req_valid = 1'b0;
        if (v.x_kld && kok) begin m_valid = 1'b1; m_key = v.key; end
        if (v.x_err) m_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        vec_t v;
        block_t pool[3];
        int r;
        logic kok, dok;
        tbl[0]  = '{MODE_ENC, K1, P,  C,  11,  0,  0, 1'b0, 1'b0};
        tbl[1]  = '{MODE_DEC, K1, C,  P,  11,  6,  0, 1'b1, 1'b0};
        tbl[2]  = '{MODE_DEC, K1, C,  P,   3,  0,  0, 1'b0, 1'b0};
        tbl[3]  = '{MODE_DEC, K2, T2, R2,  2,  4,  0, 1'b1, 1'b0};
        tbl[4]  = '{MODE_ENC, K1, P,  C,  -1,  0,  0, 1'b0, 1'b1};
        tbl[5]  = '{MODE_DEC, K2, T2, R2,  5,  3,  0, 1'b1, 1'b0};
        tbl[6]  = '{MODE_ENC, K2, T2, R2, 64,  0,  0, 1'b0, 1'b0};
        tbl[7]  = '{MODE_ENC, K2, T2, R2, 65,  0,  0, 1'b0, 1'b1};
        tbl[8]  = '{MODE_DEC, K2, T2, R2,  4, -1,  0, 1'b1, 1'b1};
        tbl[9]  = '{MODE_DEC, K2, T2, R2, 64, 64, 10, 1'b1, 1'b0};
        tbl[10] = '{MODE_DEC, K2, T2, R2,  1,  0,  3, 1'b0, 1'b0};
        pool[0] = K1; pool[1] = K2; pool[2] = K3;

        repeat (3) @(posedge clk);
        #1;
        chk_quiet_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) txn(tbl[i]);

        v = '{MODE_DEC, K3, T2, R2, 2, 3, 0, 1'b1, 1'b0};
        txn(v);
        req_valid = 1'b1; req_mode = MODE_DEC; req_key = K1; req_text = C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_seq_kld", 128'(dec_kld), 128'(1'b1));
        repeat (2) begin @(posedge clk); #1; end
        #3 rst = 1'b0;
        #1;
        chk_quiet_outputs("mid_reset");
        m_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        dec_kdone = 1'b1;
        @(posedge clk); #1;
        dec_kdone = 1'b0;
        chk("late_kdone_ignored", 128'({rsp_valid, dec_ld, dec_kld, req_ready}), 128'(4'b0001));
        v = '{MODE_DEC, K3, T2, R2, 2, 3, 0, 1'b1, 1'b0};
        txn(v);

        for (int i = 0; i < 24; i++) begin
            v.mode = 1'($urandom_range(0, 1));
            v.key = pool[$urandom_range(0, 2)];
            v.text = {4{$urandom()}};
            v.result = {4{$urandom()}};
            r = int'($urandom_range(0, 9));
            v.lat = r == 0 ? -1 : r == 1 ? TMO : r == 2 ? TMO + 1 : int'($urandom_range(1, 8));
            v.klat = $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(1, 6));
            v.bp = int'($urandom_range(0, 3));
            kok = v.klat >= 1 && v.klat <= TMO;
            dok = v.lat >= 1 && v.lat <= TMO;
            v.x_kld = v.mode == MODE_DEC && !(m_valid && v.key == m_key);
            v.x_err = (v.x_kld && !kok) || !dok;
            txn(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
